// File: rtl/op_pkg.sv
// Constants shared by the a*b+c*d operation stages and their result buffer.
package op_pkg;
    localparam int OP_DATA_W     = 16;
    localparam int OP_FIFO_DEPTH = 4;

    // STB/BUSY handshake: a word moves on an edge where STB is asserted and BUSY is not.
    localparam logic STB_ASSERT  = 1'b1;
    localparam logic BUSY_ASSERT = 1'b1;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/op_fifo_mem.sv
// Result storage: one synchronous write port, one combinational read port.
module op_fifo_mem
    import op_pkg::*;
#(
    parameter int DATA_W = OP_DATA_W,
    parameter int DEPTH  = OP_FIFO_DEPTH,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/op_result_fifo.sv
// Elastic FWFT buffer between the operation stage and the CPU response logic.
module op_result_fifo
    import op_pkg::*;
#(
    parameter int DATA_W = OP_DATA_W,
    parameter int DEPTH  = OP_FIFO_DEPTH,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] input_result,
    input  logic              fifo_input_STB,
    output logic              fifo_BUSY,
    input  logic              clear,
    output logic [DATA_W-1:0] output_result,
    output logic              fifo_output_STB,
    input  logic              output_module_BUSY,
    output logic [ADDR_W:0]   fifo_level
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              busy_q, stb_q;
    logic [DATA_W-1:0] out_q, out_d, mem_rdata;
    logic              push, pop;

    // Flags are registered, so a pop on a full edge cannot free a slot for that same edge.
    assign push = (fifo_input_STB == STB_ASSERT) && (busy_q != BUSY_ASSERT) && !clear;
    assign pop  = stb_q && (output_module_BUSY != BUSY_ASSERT) && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            // Head word is latched from the post-edge read pointer; bypass a word landing there now.
            if (count_d != '0)
                out_d = (push && (wr_ptr_q == rd_ptr_d)) ? input_result : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            stb_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= (count_d == FULL_CNT);
            stb_q    <= (count_d != '0);
            out_q    <= out_d;
        end
    end

    op_fifo_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(input_result),
        .raddr_i(rd_ptr_d),
        .rdata_o(mem_rdata)
    );

    assign fifo_BUSY       = busy_q;
    assign fifo_output_STB = stb_q;
    assign output_result   = out_q;
    assign fifo_level      = count_q;
endmodule

// File: tb/tb_op_result_fifo.sv
// Scoreboard bench for op_result_fifo: driver queues expected words, negedge monitor checks pops.
module tb_op_result_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] input_result = '0;
    logic        fifo_input_STB = 1'b0;
    logic        fifo_BUSY;
    logic        clear = 1'b0;
    logic [15:0] output_result;
    logic        fifo_output_STB;
    logic        output_module_BUSY = 1'b1;
    logic [2:0]  fifo_level;

    int vectors = 0;
    int errors  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    op_result_fifo dut (
        .clk               (clk),
        .rst               (rst),
        .input_result      (input_result),
        .fifo_input_STB    (fifo_input_STB),
        .fifo_BUSY         (fifo_BUSY),
        .clear             (clear),
        .output_result     (output_result),
        .fifo_output_STB   (fifo_output_STB),
        .output_module_BUSY(output_module_BUSY),
        .fifo_level        (fifo_level)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: any edge where the consumer will take a word must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if (fifo_level > 3'd4) begin
                errors++;
                $display("FAIL level_range: got %0d, expected <= 4", fifo_level);
            end
            if (!clear && fifo_output_STB && !output_module_BUSY) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_pop: got 0x%04h, expected no word", output_result);
                end else begin
                    chk("pop_data", output_result, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [15:0] op_stage(input int a, b, c, d);
        return 16'(a*b + c*d);
    endfunction

    // Called just after a posedge; holds STB until a BUSY-low edge transfers the word.
    task automatic push(input logic [15:0] data, input logic [15:0] exp);
        bit done = 0;
        fifo_input_STB = 1'b1;
        input_result   = data;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!fifo_BUSY && !clear) begin
                exp_q.push_back(exp);
                done = 1;
            end
            @(posedge clk); #1;
        end
        fifo_input_STB = 1'b0;
        if (!done) begin
            vectors++; errors++;
            $display("FAIL push_timeout: got BUSY stuck, expected acceptance of 0x%04h", data);
        end
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            if (fifo_level == 0 && exp_q.size() == 0) done = 1;
        end
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got level %0d / %0d pending, expected drained", name, fifo_level, exp_q.size());
        end
        chk({name, "_stb"}, 16'(fifo_output_STB), 16'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Words buffered then killed by an asynchronous mid-cycle reset.
        push(16'h1111, 16'h1111);
        push(16'h2222, 16'h2222);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_busy",  16'(fifo_BUSY), 16'h0);
        chk("rst_stb",   16'(fifo_output_STB), 16'h0);
        chk("rst_level", 16'(fifo_level), 16'h0);
        chk("rst_out",   output_result, 16'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Single word, one-cycle fall-through, then popped.
        output_module_BUSY = 1'b0;
        push(16'h1234, 16'h1234);
        chk("single_stb",   16'(fifo_output_STB), 16'h1);
        chk("single_out",   output_result, 16'h1234);
        chk("single_level", 16'(fifo_level), 16'h1);
        @(posedge clk); #1;
        chk("single_pop_stb",   16'(fifo_output_STB), 16'h0);
        chk("single_pop_level", 16'(fifo_level), 16'h0);

        // Fill against a stalled consumer; the fifth word must be refused.
        output_module_BUSY = 1'b1;
        for (int i = 1; i <= 4; i++) push(16'(i), 16'(i));
        chk("full_busy",  16'(fifo_BUSY), 16'h1);
        chk("full_level", 16'(fifo_level), 16'h4);
        fifo_input_STB = 1'b1;
        input_result   = 16'h0005;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_busy", 16'(fifo_BUSY), 16'h1);
        end
        @(posedge clk); #1 fifo_input_STB = 1'b0;
        chk("full_no_overwrite", 16'(fifo_level), 16'h4);
        output_module_BUSY = 1'b0;
        drain("full_drain");

        // Wrap: producer at full rate, consumer taking one word every other cycle.
        fork
            begin
                for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i), 16'h0100 + 16'(i));
            end
            begin
                repeat (20) begin
                    @(posedge clk); #1 output_module_BUSY = ~output_module_BUSY;
                end
            end
        join
        output_module_BUSY = 1'b0;
        drain("wrap_drain");

        // Simultaneous push and pop at level 2.
        output_module_BUSY = 1'b1;
        push(16'h0A0A, 16'h0A0A);
        push(16'h0B0B, 16'h0B0B);
        chk("pp_level_pre", 16'(fifo_level), 16'h2);
        output_module_BUSY = 1'b0;
        push(16'hBEEF, 16'hBEEF);
        output_module_BUSY = 1'b1;
        chk("pp_level", 16'(fifo_level), 16'h2);
        chk("pp_head",  output_result, 16'h0B0B);
        output_module_BUSY = 1'b0;
        drain("pp_drain");

        // Clear beats a concurrent push.
        output_module_BUSY = 1'b1;
        for (int i = 1; i <= 3; i++) push(16'h0C00 + 16'(i), 16'h0C00 + 16'(i));
        chk("clr_level_pre", 16'(fifo_level), 16'h3);
        clear = 1'b1;
        fifo_input_STB = 1'b1;
        input_result = 16'hAAAA;
        @(posedge clk); #1;
        clear = 1'b0;
        fifo_input_STB = 1'b0;
        exp_q.delete();
        chk("clr_level", 16'(fifo_level), 16'h0);
        chk("clr_stb",   16'(fifo_output_STB), 16'h0);
        chk("clr_busy",  16'(fifo_BUSY), 16'h0);
        output_module_BUSY = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("clr_stays_empty", 16'(fifo_output_STB), 16'h0);

        // Back-to-back results from the operation stage model.
        push(op_stage(5, 6, 7, 8), 16'h0056);
        push(op_stage(2, 3, 4, 5), 16'h001A);
        drain("op_drain");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/op_result_fifo.md
Name: op_result_fifo

Overview:
- Elastic result buffer directly downstream of the a*b+c*d operation stage. It decouples that stage from the slower consumer: the CPU-side co-processor response logic.
- Accepts 16-bit results over the STB/BUSY handshake and stores them in a small circular FIFO.
- Presents the results in order over the same handshake to the output module, so the operation stage can start its next job without waiting on the CPU.

Parameters:
- DATA_W, 16, width of one result word
- DEPTH, 4, number of entries; must be a power of two, 2..16
- ADDR_W, 2, log2(DEPTH); pointer width

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets the block); one clock domain only
- input_result  input  DATA_W  result word from the operation stage
- fifo_input_STB  input  1  producer strobe; input_result is valid while high
- fifo_BUSY  output  1  high when no entry is free; producer must hold
- clear  input  1  synchronous flush; discards all stored entries
- output_result  output  DATA_W  head-of-FIFO word
- fifo_output_STB  output  1  high when output_result holds a valid entry
- output_module_BUSY  input  1  consumer back-pressure
- fifo_level  output  ADDR_W+1  number of stored entries, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - wr_ptr=0, rd_ptr=0, count=0.
  - fifo_BUSY=0, fifo_output_STB=0, fifo_level=0, output_result=0.
  - Storage contents are don't-care.
- Push:
  - Occurs on a rising edge where fifo_input_STB=1, fifo_BUSY=0 and clear=0.
  - Writes mem[wr_ptr]=input_result, then wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
  - The producer drops STB on the same edge it sees BUSY low, so each edge with STB&&!BUSY is exactly one transfer. The FIFO must not re-capture a held STB as a second word unless a second such edge occurs.
- Pop:
  - Occurs on a rising edge where fifo_output_STB=1, output_module_BUSY=0 and clear=0.
  - rd_ptr increments modulo DEPTH.
- Count:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- fifo_BUSY:
  - Registered: equals (count==DEPTH) after every edge.
  - A pop on the edge where the FIFO is full does not allow a push on that same edge. BUSY deasserts one cycle later.
- fifo_output_STB:
  - Registered: equals (count!=0).
  - output_result is the word at mem[rd_ptr] as updated on the same edge (first-word-fall-through).
- Latency:
  - A word pushed at edge k appears on output_result with fifo_output_STB=1 after edge k (one cycle) when the FIFO was empty.
  - When non-empty, words appear in push order.
- Empty:
  - A push and a pop cannot coincide because STB is low.
  - output_result holds its last value; the consumer must ignore it.
- Full: push is ignored (BUSY high) and no data is overwritten.
- clear=1:
  - Has priority over push and pop.
  - Pointers and count go to 0, fifo_output_STB=0, fifo_BUSY=0 after the edge.
  - A simultaneous push is dropped.
- Reset mid-operation discards all entries. The producer and consumer see BUSY=0 and STB=0 immediately.
- fifo_level equals count.
- No internal state machine beyond the pointers and count. The FSM-level behaviour is the handshake above.

Decomposition:
- Shared package op_pkg holds:
  - constant OP_DATA_W=16, shared with the operation stages
  - the handshake documentation constants
  - localparam helpers for ADDR_W
- One sub-module, op_fifo_mem: DEPTH x DATA_W register array with one synchronous write port and one combinational read port.
- The pointer, count and flag logic stays in op_result_fifo.

Test Plan:
- Reset, then push a single word:
  - Stimulus: assert rst=0 mid-cycle, check outputs immediately. Release rst, push 0x1234.
  - Response: all outputs 0 during reset. After the next edge, fifo_output_STB=1, output_result=0x1234, fifo_level=1. Pop with BUSY=0 -> STB=0, level=0.
- Fill to full with output_module_BUSY=1:
  - Stimulus: push 0x0001..0x0004, then attempt to push 0x0005.
  - Response: fifo_BUSY=1 after the 4th edge and 0x0005 is not stored. Release consumer BUSY -> outputs 0x0001, 0x0002, 0x0003, 0x0004 in order, then STB=0.
- Wrap-around:
  - Stimulus: push 6 words while popping 1 per 2 cycles.
  - Response: order preserved across the pointer wrap. fifo_level never exceeds 4 and never underflows.
- Simultaneous push and pop at level 2:
  - Stimulus: push 0xBEEF on the same edge as a pop.
  - Response: level stays 2, the head advances, and 0xBEEF is output last.
- Clear with a concurrent push:
  - Stimulus: with 3 entries stored, assert clear=1 together with STB=1 and data 0xAAAA.
  - Response: level=0, STB=0, BUSY=0 after the edge; 0xAAAA is never output.
- Back-to-back with the operation stage:
  - Stimulus: connect to a model producing results 5*6+7*8=86 (0x0056) and 2*3+4*5=26 (0x001A).
  - Response: the consumer receives 0x0056 then 0x001A, each exactly once.
